// File: rtl/gmii_tx_mac_if.sv
`default_nettype none
// ============================================================================
//  Module   : gmii_tx_mac_if
//  Brief    : Byte-stream handshake bundle feeding the GMII transmit framer.
//  Revision : 1.0 - initial release
// ============================================================================
interface gmii_tx_mac_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_err;
    logic       s_ready;

    modport master (
        output s_data,
        output s_valid,
        output s_last,
        output s_err,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        input  s_err,
        output s_ready
    );
endinterface
`default_nettype wire

// File: rtl/gmii_tx_mac.sv
`default_nettype none
// ============================================================================
//  Module   : gmii_tx_mac
//  Brief    : Gigabit MAC TX framer: preamble/SFD, zero pad, CRC-32 FCS, IFG.
//  Revision : 1.0 - initial release
// ============================================================================
module gmii_tx_mac #(
    parameter int MIN_FRAME    = 60,
    parameter int IFG_BYTES    = 12,
    parameter int PREAMBLE_LEN = 7
) (
    input  wire logic       gmii_tx_clk,
    input  wire logic       reset_n,
    gmii_tx_mac_if.slave    s_bus,
    output logic [7:0]      gmii_txd,
    output logic            gmii_tx_en,
    output logic            gmii_tx_er,
    output logic            busy,
    output logic            frame_done,
    output logic            underrun
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_PRE   = 3'd1;
    localparam logic [2:0] c_ST_SFD   = 3'd2;
    localparam logic [2:0] c_ST_DATA  = 3'd3;
    localparam logic [2:0] c_ST_PAD   = 3'd4;
    localparam logic [2:0] c_ST_FCS   = 3'd5;
    localparam logic [2:0] c_ST_DRAIN = 3'd6;
    localparam logic [2:0] c_ST_IFG   = 3'd7;

    localparam logic [15:0] c_MIN_FRAME = 16'(MIN_FRAME);
    localparam logic [15:0] c_IFG_LAST  = 16'(IFG_BYTES - 1);
    localparam logic [15:0] c_PRE_LAST  = 16'(PREAMBLE_LEN - 1);

    logic [2:0]  r_state;
    logic [15:0] r_byte_cnt;
    logic [15:0] r_aux_cnt;     // preamble index, FCS byte index or gap count
    logic [31:0] r_crc;

    logic [15:0] w_cnt_inc;
    logic [31:0] w_crc_data;
    logic [31:0] w_crc_zero;
    logic [31:0] w_fcs;

    // Reflected CRC-32, one byte per call, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'd0, d};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    assign w_cnt_inc  = (r_byte_cnt == 16'hFFFF) ? r_byte_cnt : r_byte_cnt + 16'd1;
    assign w_crc_data = crc_byte(r_crc, s_bus.s_data);
    assign w_crc_zero = crc_byte(r_crc, 8'h00);
    assign w_fcs      = ~r_crc;

    assign s_bus.s_ready = (r_state == c_ST_DATA) || (r_state == c_ST_DRAIN);
    assign busy          = (r_state != c_ST_IDLE);

    // The byte chosen in a state lands on the wire one cycle later; IDLE
    // already selects the first preamble byte so back-to-back gaps stay exact.
    always_ff @(posedge gmii_tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_ST_IDLE;
            r_byte_cnt <= 16'd0;
            r_aux_cnt  <= 16'd0;
            r_crc      <= 32'hFFFF_FFFF;
            gmii_txd   <= 8'h00;
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            gmii_txd   <= 8'h00;
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (s_bus.s_valid) begin
                        gmii_txd   <= 8'h55;
                        gmii_tx_en <= 1'b1;
                        r_aux_cnt  <= 16'd1;
                        r_state    <= (PREAMBLE_LEN > 1) ? c_ST_PRE : c_ST_SFD;
                    end
                end

                c_ST_PRE: begin
                    gmii_txd   <= 8'h55;
                    gmii_tx_en <= 1'b1;
                    r_aux_cnt  <= r_aux_cnt + 16'd1;
                    if (r_aux_cnt >= c_PRE_LAST) begin
                        r_state <= c_ST_SFD;
                    end
                end

                c_ST_SFD: begin
                    gmii_txd   <= 8'hD5;
                    gmii_tx_en <= 1'b1;
                    r_crc      <= 32'hFFFF_FFFF;
                    r_byte_cnt <= 16'd0;
                    r_state    <= c_ST_DATA;
                end

                c_ST_DATA: begin
                    gmii_tx_en <= 1'b1;
                    if (s_bus.s_valid) begin
                        gmii_txd   <= s_bus.s_data;
                        gmii_tx_er <= s_bus.s_err;
                        r_crc      <= w_crc_data;
                        r_byte_cnt <= w_cnt_inc;
                        if (s_bus.s_last) begin
                            r_aux_cnt <= 16'd0;
                            r_state   <= (w_cnt_inc < c_MIN_FRAME) ? c_ST_PAD : c_ST_FCS;
                        end
                    end else begin
                        gmii_tx_er <= 1'b1;
                        underrun   <= 1'b1;
                        r_state    <= c_ST_DRAIN;
                    end
                end

                c_ST_PAD: begin
                    gmii_tx_en <= 1'b1;
                    r_crc      <= w_crc_zero;
                    r_byte_cnt <= w_cnt_inc;
                    if (w_cnt_inc >= c_MIN_FRAME) begin
                        r_aux_cnt <= 16'd0;
                        r_state   <= c_ST_FCS;
                    end
                end

                c_ST_FCS: begin
                    gmii_txd   <= w_fcs[{r_aux_cnt[1:0], 3'b000} +: 8];
                    gmii_tx_en <= 1'b1;
                    r_aux_cnt  <= r_aux_cnt + 16'd1;
                    if (r_aux_cnt[1:0] == 2'd3) begin
                        frame_done <= 1'b1;
                        r_aux_cnt  <= 16'd0;
                        r_state    <= c_ST_IFG;
                    end
                end

                c_ST_DRAIN: begin
                    if (s_bus.s_valid && s_bus.s_last) begin
                        r_aux_cnt <= 16'd0;
                        r_state   <= c_ST_IFG;
                    end
                end

                c_ST_IFG: begin
                    r_aux_cnt <= r_aux_cnt + 16'd1;
                    if (r_aux_cnt >= c_IFG_LAST) begin
                        r_state <= c_ST_IDLE;
                    end
                end

                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gmii_tx_mac.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_gmii_tx_mac
//  Brief    : Scoreboard bench for the GMII TX framer, directed frames.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gmii_tx_mac;

    localparam int MIN_FRAME    = 60;
    localparam int IFG_BYTES    = 12;
    localparam int PREAMBLE_LEN = 7;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic       busy;
    logic       frame_done;
    logic       underrun;

    gmii_tx_mac_if sif();

    gmii_tx_mac #(
        .MIN_FRAME    (MIN_FRAME),
        .IFG_BYTES    (IFG_BYTES),
        .PREAMBLE_LEN (PREAMBLE_LEN)
    ) dut (
        .gmii_tx_clk (clk),
        .reset_n     (reset_n),
        .s_bus       (sif),
        .gmii_txd    (gmii_txd),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_tx_er  (gmii_tx_er),
        .busy        (busy),
        .frame_done  (frame_done),
        .underrun    (underrun)
    );

    always #4 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       er;
        logic       done;
        logic       ur;
    } exp_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    exp_t       exp_q[$];
    logic [7:0] pay[$];
    int         runs[$];
    int         gaps[$];
    logic [7:0] cap[$];
    logic [7:0] last_frame[$];
    bit         prev_en  = 1'b0;
    bit         seen     = 1'b0;
    int         run_len  = 0;
    int         idle_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'd0, d};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction

    task automatic push(input logic [7:0] d, input logic er, input logic done, input logic ur);
        exp_t e;
        e.d = d; e.er = er; e.done = done; e.ur = ur;
        exp_q.push_back(e);
    endtask

    // Expected wire image of the frame currently held in pay.
    task automatic push_exp(input int err_idx, input int ur_after);
        logic [31:0] crc;
        int          lim;
        crc = 32'hFFFF_FFFF;
        lim = (ur_after >= 0) ? ur_after : pay.size();
        for (int i = 0; i < PREAMBLE_LEN; i++) push(8'h55, 1'b0, 1'b0, 1'b0);
        push(8'hD5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < lim; i++) begin
            push(pay[i], (i == err_idx), 1'b0, 1'b0);
            crc = crc_upd(crc, pay[i]);
        end
        if (ur_after >= 0) begin
            push(8'h00, 1'b1, 1'b0, 1'b1);
        end else begin
            for (int i = pay.size(); i < MIN_FRAME; i++) begin
                push(8'h00, 1'b0, 1'b0, 1'b0);
                crc = crc_upd(crc, 8'h00);
            end
            crc = ~crc;
            push(crc[7:0],   1'b0, 1'b0, 1'b0);
            push(crc[15:8],  1'b0, 1'b0, 1'b0);
            push(crc[23:16], 1'b0, 1'b0, 1'b0);
            push(crc[31:24], 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic xfer(input logic [7:0] d, input logic last, input logic err);
        bit r;
        bit ok = 1'b0;
        sif.s_data  = d;
        sif.s_last  = last;
        sif.s_err   = err;
        sif.s_valid = 1'b1;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            r = sif.s_ready;
            @(posedge clk);
            #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        chk("xfer_accept", ok, 1);
    endtask

    task automatic drive(input int err_idx, input int ur_after);
        for (int i = 0; i < pay.size(); i++) begin
            if (i == ur_after) begin
                sif.s_valid = 1'b0;
                @(posedge clk);
                #1;
                chk("drain_ready", sif.s_ready, 1);
            end
            xfer(pay[i], (i == pay.size() - 1), (i == err_idx));
        end
    endtask

    task automatic stop_inputs();
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        sif.s_err   = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!busy && !gmii_tx_en && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk({nm, "_idle"}, ok, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: every enabled wire byte is popped from the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (gmii_tx_en) begin
                if (!prev_en) begin
                    if (seen) gaps.push_back(idle_cnt);
                    run_len = 0;
                    cap.delete();
                end
                run_len++;
                cap.push_back(gmii_txd);
                chk("exp_avail", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("txd", gmii_txd, e.d);
                    chk("tx_er", gmii_tx_er, e.er);
                    chk("frame_done", frame_done, e.done);
                    chk("underrun", underrun, e.ur);
                end
            end else begin
                if (prev_en) begin
                    runs.push_back(run_len);
                    seen     = 1'b1;
                    idle_cnt = 0;
                end
                idle_cnt++;
                chk("idle_out", {gmii_txd, gmii_tx_er, frame_done, underrun}, 0);
            end
            if (frame_done) last_frame = cap;
            prev_en = gmii_tx_en;
        end else begin
            prev_en  = 1'b0;
            seen     = 1'b0;
            idle_cnt = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        stop_inputs();
        sif.s_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", gmii_txd, 0);
        chk("rst_tx_en", gmii_tx_en, 0);
        chk("rst_tx_er", gmii_tx_er, 0);
        chk("rst_s_ready", sif.s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_underrun", underrun, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 1-byte frame, padded to minimum
        pay = '{8'hAB};
        push_exp(-1, -1);
        drive(-1, -1);
        stop_inputs();
        wait_idle("one_byte");
        chk("run_one_byte", (runs.size() > 0) ? runs[0] : -1, 72);

        // 64-byte frame, FCS residual
        runs.delete(); gaps.delete();
        pay.delete();
        for (int i = 0; i < 64; i++) pay.push_back(8'(i));
        push_exp(-1, -1);
        drive(-1, -1);
        stop_inputs();
        wait_idle("frame64");
        chk("run_frame64", (runs.size() > 0) ? runs[0] : -1, 76);
        chk("cap_len64", last_frame.size(), 76);
        res = 32'hFFFF_FFFF;
        for (int i = PREAMBLE_LEN + 1; i < last_frame.size(); i++) res = crc_upd(res, last_frame[i]);
        chk("fcs_residual", ~res, 32'h2144_DF1C);

        // back-to-back 60-byte frames with s_valid held
        runs.delete(); gaps.delete();
        pay.delete();
        for (int i = 0; i < 60; i++) pay.push_back(8'(i) ^ 8'h5A);
        push_exp(-1, -1);
        drive(-1, -1);
        pay.delete();
        for (int i = 0; i < 60; i++) pay.push_back(8'(i) + 8'h80);
        push_exp(-1, -1);
        drive(-1, -1);
        stop_inputs();
        wait_idle("b2b");
        chk("run_b2b_1", (runs.size() > 0) ? runs[0] : -1, 72);
        chk("run_b2b_2", (runs.size() > 1) ? runs[1] : -1, 72);
        chk("gap_b2b", (gaps.size() > 1) ? gaps[1] : -1, IFG_BYTES);

        // underrun after 10 bytes, then a frame with s_err on byte 5
        runs.delete(); gaps.delete();
        pay.delete();
        for (int i = 0; i < 20; i++) pay.push_back(8'(i + 1));
        push_exp(-1, 10);
        drive(-1, 10);
        pay.delete();
        for (int i = 0; i < 20; i++) pay.push_back(8'hC0 + 8'(i));
        push_exp(5, -1);
        drive(5, -1);
        stop_inputs();
        wait_idle("underrun_err");
        chk("run_underrun", (runs.size() > 0) ? runs[0] : -1, PREAMBLE_LEN + 1 + 10 + 1);
        chk("run_err", (runs.size() > 1) ? runs[1] : -1, 72);
        chk("gap_after_drain", (gaps.size() > 1) ? gaps[1] : -1, 10 + IFG_BYTES);

        // reset asserted while padding
        pay = '{8'h11};
        push_exp(-1, -1);
        drive(-1, -1);
        stop_inputs();
        repeat (20) @(posedge clk);
        #1;
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_tx_en", gmii_tx_en, 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_tx_en", gmii_tx_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_txd", gmii_txd, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        runs.delete(); gaps.delete();
        pay = '{8'h22};
        push_exp(-1, -1);
        sif.s_data  = 8'h22;
        sif.s_last  = 1'b1;
        sif.s_err   = 1'b0;
        sif.s_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_tx_en", gmii_tx_en, 1);
        chk("restart_txd", gmii_txd, 8'h55);
        drive(-1, -1);
        stop_inputs();
        wait_idle("restart");
        chk("run_restart", (runs.size() > 0) ? runs[0] : -1, 72);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
